logic_unit_arbiter: RTL and testbench
=====================================

// Module: logic_unit_arbiter
// PURPOSE
//   Shares one bitwise logic unit (AND/OR/XOR/NOR/NAND) among NUM_REQ requesters.
//   Round-robin arbitration with per-requester valid/ready, a 3-state sequencer,
//   and a registered response channel tagged with the winner's ID.
//   Sits between requester blocks and the shared logic datapath.
// PARAMETERS
//   NUM_REQ  4  number of requesters (2..8)
//   DATA_W   8  operand/result width in bits
//   ID_W     2  width of rsp_id; must equal clog2(NUM_REQ)
// PORTS
//   clk        in   1               single clock, rising edge
//   rst_n      in   1               synchronous reset, active-low
//   req_valid  in   NUM_REQ         per-requester request valid
//   req_ready  out  NUM_REQ         per-requester accept; one-hot or zero
//   req_op     in   NUM_REQ*3       op code per requester; slice i = [3*i+:3]
//   req_x      in   NUM_REQ*DATA_W  operand x per requester; slice [DATA_W*i+:DATA_W]
//   req_y      in   NUM_REQ*DATA_W  operand y per requester; same slicing
//   rsp_valid  out  1               response valid
//   rsp_ready  in   1               response consumer ready
//   rsp_id     out  ID_W            index of the requester served
//   rsp_data   out  DATA_W          result
//   rsp_err    out  1               illegal op code; rsp_data = 0
//   busy       out  1               high in any state other than IDLE
// BEHAVIOUR
//   - Reset (rst_n=0 at a clk edge): state=IDLE; rsp_valid, rsp_id, rsp_data, rsp_err = 0;
//     req_ready=0; last_grant=NUM_REQ-1, so requester 0 has first priority.
//     Reset during EXEC or RESP drops the transaction. No response is produced.
//   - Op codes: 0 AND, 1 OR, 2 XOR, 3 NOR, 4 NAND, bitwise over DATA_W bits.
//     Codes 5..7 are illegal: rsp_data=0 and rsp_err=1.
//   - FSM states: IDLE -> EXEC -> RESP -> IDLE.
//     IDLE: when any req_valid=1, pick the first valid index searching from
//       last_grant+1 upward, modulo NUM_REQ. req_ready[winner]=1 combinationally
//       in that cycle, and the handshake completes there. Latch op, x, y and id.
//       Go to EXEC. If no request is valid, stay in IDLE.
//     EXEC: drive the latched operands through logic_unit. Register the result and
//       err flag into the rsp_* outputs. Set rsp_valid=1. Go to RESP.
//     RESP: hold rsp_valid and all rsp_* stable until rsp_ready=1. On that
//       handshake edge: rsp_valid goes to 0, last_grant takes the served id,
//       and the FSM returns to IDLE.
//   - Latency: accept in cycle N gives rsp_valid=1 in cycle N+2.
//     Minimum spacing is 3 cycles per transaction.
//   - req_ready is 0 outside IDLE. Requesters hold op, x and y stable while valid
//     until they see ready.
//   - Non-winners keep waiting. A winner is not granted again while another
//     requester is valid, which gives fairness bounded at NUM_REQ grants.
//   - rsp_id/rsp_data/rsp_err keep their last values after the handshake.
//     Only rsp_valid is defined outside RESP.
//   - Pointer wrap: last_grant=NUM_REQ-1 means the search starts at index 0.
// STRUCTURE
//   - logic_unit_pkg: op code localparams (OP_AND..OP_NAND), FSM state encoding
//     (S_IDLE, S_EXEC, S_RESP).
//   - Sub-module logic_unit #(DATA_W): purely combinational.
//     Inputs op/x/y; outputs res/err.
//   - Arbiter: rotate-priority-encode-unrotate.
// TESTING
//   1 Reset: hold rst_n=0 for 3 cycles -> all outputs 0, busy=0.
//   2 Single request: r0 op=0 x=8'hF0 y=8'h3C, accepted in N
//     -> rsp_valid at N+2, rsp_data=8'h30, rsp_id=0, rsp_err=0.
//   3 All ops, same x=8'hF0 y=8'h3C -> AND 30, OR FC, XOR CC, NOR 03, NAND CF.
//     Op 6 -> data 00, err 1.
//   4 Fairness: req_valid=4'b1111 held continuously
//     -> grant order 0,1,2,3,0. Each req_ready is one-hot.
//   5 Backpressure: rsp_ready=0 for 5 cycles -> rsp_* stable, busy=1, no req_ready.
//     Then rsp_ready=1 -> completes next edge.
//   6 Reset in EXEC: pull rst_n=0 one cycle after accept -> no rsp_valid.
//     The next grant goes to requester 0.

Source files
------------

// File: rtl/logic_unit_pkg.sv
// Shared definitions for the logic-unit arbiter: op codes and sequencer states.
package logic_unit_pkg;

    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_XOR  = 3'd2;
    localparam logic [2:0] OP_NOR  = 3'd3;
    localparam logic [2:0] OP_NAND = 3'd4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/logic_unit.sv
// Combinational bitwise logic unit; op codes above NAND flag an error and yield zero.
module logic_unit
    import logic_unit_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] x,
    input  logic [DATA_W-1:0] y,
    output logic [DATA_W-1:0] res,
    output logic              err
);

    always_comb begin
        res = '0;
        err = 1'b0;
        case (op)
            OP_AND:  res = x & y;
            OP_OR:   res = x | y;
            OP_XOR:  res = x ^ y;
            OP_NOR:  res = ~(x | y);
            OP_NAND: res = ~(x & y);
            default: err = 1'b1;
        endcase
    end

endmodule

// File: rtl/logic_unit_arbiter.sv
// Round-robin sharing of one logic_unit among NUM_REQ requesters.
// States: IDLE = wait/grant | EXEC = compute into rsp_* | RESP = hold until rsp_ready.
module logic_unit_arbiter
    import logic_unit_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8,
    parameter int ID_W    = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*3-1:0]      req_op,
    input  logic [NUM_REQ*DATA_W-1:0] req_x,
    input  logic [NUM_REQ*DATA_W-1:0] req_y,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [ID_W-1:0]           rsp_id,
    output logic [DATA_W-1:0]         rsp_data,
    output logic                      rsp_err,
    output logic                      busy
);

    state_t            state_q, state_d;
    logic [ID_W-1:0]   last_grant_q, last_grant_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [2:0]        op_q, op_d;
    logic [DATA_W-1:0] x_q, x_d, y_q, y_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic              rsp_err_q, rsp_err_d;

    logic [2*NUM_REQ-1:0] dbl_valid;
    logic [NUM_REQ-1:0]   rot_valid;
    logic                 any_valid;
    logic [ID_W-1:0]      winner;
    int                   arb_start, arb_enc;
    logic [2:0]           op_sel;
    logic [DATA_W-1:0]    x_sel, y_sel, lu_res;
    logic                 lu_err;

    // Rotate so the slot after last_grant sits at bit 0, pick lowest, rotate back.
    always_comb begin
        arb_start = (int'(last_grant_q) + 1) % NUM_REQ;
        dbl_valid = {req_valid, req_valid} >> arb_start;
        rot_valid = dbl_valid[NUM_REQ-1:0];
        arb_enc   = 0;
        any_valid = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!any_valid && rot_valid[i]) begin
                arb_enc   = i;
                any_valid = 1'b1;
            end
        end
        winner = ID_W'((arb_enc + arb_start) % NUM_REQ);
    end

    always_comb begin
        op_sel = '0;
        x_sel  = '0;
        y_sel  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winner == ID_W'(i)) begin
                op_sel = req_op[3*i +: 3];
                x_sel  = req_x[DATA_W*i +: DATA_W];
                y_sel  = req_y[DATA_W*i +: DATA_W];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state_q == S_IDLE && any_valid) req_ready[winner] = 1'b1;
    end

    logic_unit #(.DATA_W(DATA_W)) u_logic_unit (
        .op  (op_q),
        .x   (x_q),
        .y   (y_q),
        .res (lu_res),
        .err (lu_err)
    );

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        id_d         = id_q;
        op_d         = op_q;
        x_d          = x_q;
        y_d          = y_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_data_d   = rsp_data_q;
        rsp_err_d    = rsp_err_q;
        case (state_q)
            S_IDLE: begin
                if (any_valid) begin
                    op_d    = op_sel;
                    x_d     = x_sel;
                    y_d     = y_sel;
                    id_d    = winner;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                rsp_data_d  = lu_res;
                rsp_err_d   = lu_err;
                rsp_id_d    = id_q;
                rsp_valid_d = 1'b1;
                state_d     = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d  = 1'b0;
                    last_grant_d = rsp_id_q;
                    state_d      = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            last_grant_q <= ID_W'(NUM_REQ - 1);
            id_q         <= '0;
            op_q         <= '0;
            x_q          <= '0;
            y_q          <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
            rsp_data_q   <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            id_q         <= id_d;
            op_q         <= op_d;
            x_q          <= x_d;
            y_q          <= y_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_data_q   <= rsp_data_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Directed-vector bench for logic_unit_arbiter with hand-computed expectations.
module tb_logic_unit_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [11:0] req_op;
    logic [31:0] req_x;
    logic [31:0] req_y;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic [7:0]  rsp_data;
    logic        rsp_err;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;

    logic_unit_arbiter #(.NUM_REQ(4), .DATA_W(8), .ID_W(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_x     (req_x),
        .req_y     (req_y),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        req_op    = '0;
        req_x     = '0;
        req_y     = '0;
        rsp_ready = 1'b1;
        repeat (3) step();
        @(negedge clk);
        n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
        n_cmp++; if (rsp_id !== 2'd0) begin n_err++; $display("FAIL reset_rsp_id got %0d want 0", rsp_id); end
        n_cmp++; if (rsp_data !== 8'h00) begin n_err++; $display("FAIL reset_rsp_data got %h want 00", rsp_data); end
        n_cmp++; if (rsp_err !== 1'b0) begin n_err++; $display("FAIL reset_rsp_err got %b want 0", rsp_err); end
        n_cmp++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL reset_req_ready got %b want 0000", req_ready); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
        rst_n = 1'b1;
        step();
    endtask

    // One isolated transaction from requester idx; entered and left at posedge+1 in IDLE.
    task automatic run_txn(input int idx, input logic [2:0] op, input logic [7:0] x,
                           input logic [7:0] y, input logic [7:0] exp_data, input logic exp_err);
        logic [3:0] exp_rdy;
        exp_rdy      = '0;
        exp_rdy[idx] = 1'b1;
        req_op[3*idx +: 3] = op;
        req_x[8*idx +: 8]  = x;
        req_y[8*idx +: 8]  = y;
        req_valid = exp_rdy;
        rsp_ready = 1'b1;
        @(negedge clk);
        n_cmp++; if (req_ready !== exp_rdy) begin n_err++; $display("FAIL txn_ready op%0d got %b want %b", op, req_ready, exp_rdy); end
        step();
        req_valid = '0;
        @(negedge clk);
        n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL txn_early_valid op%0d got %b want 0", op, rsp_valid); end
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL txn_busy op%0d got %b want 1", op, busy); end
        step();
        @(negedge clk);
        n_cmp++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL txn_valid op%0d got %b want 1", op, rsp_valid); end
        n_cmp++; if (rsp_id !== 2'(idx)) begin n_err++; $display("FAIL txn_id op%0d got %0d want %0d", op, rsp_id, idx); end
        n_cmp++; if (rsp_data !== exp_data) begin n_err++; $display("FAIL txn_data op%0d got %h want %h", op, rsp_data, exp_data); end
        n_cmp++; if (rsp_err !== exp_err) begin n_err++; $display("FAIL txn_err op%0d got %b want %b", op, rsp_err, exp_err); end
        step();
        @(negedge clk);
        n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL txn_done op%0d got %b want 0", op, rsp_valid); end
        step();
    endtask

    task automatic test_single();
        run_txn(0, 3'd0, 8'hF0, 8'h3C, 8'h30, 1'b0);
    endtask

    task automatic test_all_ops();
        logic [2:0] ops  [7] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd6, 3'd5};
        logic [7:0] exps [7] = '{8'h30, 8'hFC, 8'hCC, 8'h03, 8'hCF, 8'h00, 8'h00};
        logic       errs [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        for (int k = 0; k < 7; k++) run_txn(k % 4, ops[k], 8'hF0, 8'h3C, exps[k], errs[k]);
    endtask

    task automatic test_fairness();
        int order [5] = '{0, 1, 2, 3, 0};
        logic [3:0] exp_rdy;
        int gi = 0;
        int ri = 0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req_op[3*i +: 3] = 3'd1;
            req_x[8*i +: 8]  = 8'h11 * 8'(i);
            req_y[8*i +: 8]  = 8'h00;
        end
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            n_cmp++; if ($countones(req_ready) > 1) begin n_err++; $display("FAIL fair_onehot cyc%0d got %b want one-hot", c, req_ready); end
            if (req_ready != 4'b0000 && gi < 5) begin
                exp_rdy = '0;
                exp_rdy[order[gi]] = 1'b1;
                n_cmp++; if (req_ready !== exp_rdy) begin n_err++; $display("FAIL fair_grant%0d got %b want %b", gi, req_ready, exp_rdy); end
                gi++;
            end
            if (rsp_valid === 1'b1 && ri < 5) begin
                n_cmp++; if (rsp_id !== 2'(order[ri])) begin n_err++; $display("FAIL fair_id%0d got %0d want %0d", ri, rsp_id, order[ri]); end
                n_cmp++; if (rsp_data !== 8'h11 * 8'(order[ri])) begin n_err++; $display("FAIL fair_data%0d got %h want %h", ri, rsp_data, 8'h11 * 8'(order[ri])); end
                ri++;
            end
            step();
            if (gi == 5) req_valid = '0;
        end
        n_cmp++; if (gi != 5) begin n_err++; $display("FAIL fair_grant_count got %0d want 5", gi); end
        n_cmp++; if (ri != 5) begin n_err++; $display("FAIL fair_rsp_count got %0d want 5", ri); end
    endtask

    task automatic test_backpressure();
        req_op[6 +: 3] = 3'd2;
        req_x[16 +: 8] = 8'hAA;
        req_y[16 +: 8] = 8'hFF;
        req_valid = 4'b0100;
        rsp_ready = 1'b0;
        @(negedge clk);
        n_cmp++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL bp_accept got %b want 0100", req_ready); end
        step();
        req_valid = 4'b0010;
        step();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_cmp++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid cyc%0d got %b want 1", c, rsp_valid); end
            n_cmp++; if (rsp_data !== 8'h55) begin n_err++; $display("FAIL bp_data cyc%0d got %h want 55", c, rsp_data); end
            n_cmp++; if (rsp_id !== 2'd2) begin n_err++; $display("FAIL bp_id cyc%0d got %0d want 2", c, rsp_id); end
            n_cmp++; if (rsp_err !== 1'b0) begin n_err++; $display("FAIL bp_err cyc%0d got %b want 0", c, rsp_err); end
            n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL bp_busy cyc%0d got %b want 1", c, busy); end
            n_cmp++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL bp_no_ready cyc%0d got %b want 0000", c, req_ready); end
            step();
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        n_cmp++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL bp_before_hs got %b want 1", rsp_valid); end
        step();
        req_valid = '0;
        @(negedge clk);
        n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL bp_after_hs got %b want 0", rsp_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL bp_idle_busy got %b want 0", busy); end
        n_cmp++; if (rsp_data !== 8'h55) begin n_err++; $display("FAIL bp_data_hold got %h want 55", rsp_data); end
        step();
    endtask

    task automatic test_reset_in_exec();
        run_txn(0, 3'd0, 8'hF0, 8'h3C, 8'h30, 1'b0);
        req_op[3 +: 3] = 3'd1;
        req_valid = 4'b0010;
        @(negedge clk);
        n_cmp++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL rexec_accept got %b want 0010", req_ready); end
        step();
        rst_n     = 1'b0;
        req_valid = '0;
        step();
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL rexec_valid0 got %b want 0", rsp_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rexec_busy got %b want 0", busy); end
        step();
        @(negedge clk);
        n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL rexec_valid1 got %b want 0", rsp_valid); end
        req_valid = 4'b1111;
        #1;
        n_cmp++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL rexec_next_grant got %b want 0001", req_ready); end
        req_valid = '0;
        step();
    endtask

    initial begin
        test_reset();
        test_single();
        test_all_ops();
        test_fairness();
        test_backpressure();
        test_reset_in_exec();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
